// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU control sequencer: FSM state encoding and opcodes.
// The datapath and ALU import the same opcode values.
package cpu_seq_pkg;

  localparam int OP_W   = 3;
  localparam int WORD_W = 8;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH_A,
    S_FETCH_D,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
  localparam logic [OP_W-1:0] OP_BNE   = 3'b101;
  localparam logic [OP_W-1:0] OP_NOP   = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memories (slave).
interface cpu_sequencer_if;
  import cpu_seq_pkg::*;

  logic [OP_W-1:0] op;
  logic z_flag;
  logic mem_ready;

  logic PC_bus, INC_PC, load_PC, load_IR, Addr_bus;
  logic load_MAR, MDR_bus, load_MDR, CS, R_NW;
  logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor;
  logic halted;

  modport master (
    input  op, z_flag, mem_ready,
    output PC_bus, INC_PC, load_PC, load_IR, Addr_bus,
           load_MAR, MDR_bus, load_MDR, CS, R_NW,
           ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor,
           halted
  );

  modport slave (
    output op, z_flag, mem_ready,
    input  PC_bus, INC_PC, load_PC, load_IR, Addr_bus,
           load_MAR, MDR_bus, load_MDR, CS, R_NW,
           ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor,
           halted
  );

endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM for the shared-sysbus CPU, with memory wait states.
// Outputs are decoded from the state so an async reset clears them the same instant.
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic            clock,
  input  logic            n_reset,
  cpu_sequencer_if.master bus
);

  state_t state, nextState;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= S_RESET;
    else          state <= nextState;
  end

  // R_NW idles high so the memory never sees a write unless STORE executes.
  always_comb begin
    nextState    = state;
    bus.PC_bus   = 1'b0;
    bus.INC_PC   = 1'b0;
    bus.load_PC  = 1'b0;
    bus.load_IR  = 1'b0;
    bus.Addr_bus = 1'b0;
    bus.load_MAR = 1'b0;
    bus.MDR_bus  = 1'b0;
    bus.load_MDR = 1'b0;
    bus.CS       = 1'b0;
    bus.R_NW     = 1'b1;
    bus.ACC_bus  = 1'b0;
    bus.load_ACC = 1'b0;
    bus.ALU_ACC  = 1'b0;
    bus.ALU_add  = 1'b0;
    bus.ALU_sub  = 1'b0;
    bus.ALU_xor  = 1'b0;
    bus.halted   = 1'b0;
    case (state)
      S_RESET: nextState = S_FETCH_A;
      S_FETCH_A: begin
        bus.PC_bus   = 1'b1;
        bus.load_MAR = 1'b1;
        bus.INC_PC   = 1'b1;
        nextState    = S_FETCH_D;
      end
      S_FETCH_D: begin
        bus.CS      = 1'b1;
        bus.MDR_bus = 1'b1;
        bus.load_IR = bus.mem_ready;
        if (bus.mem_ready) nextState = S_DECODE;
      end
      S_DECODE: begin
        case (bus.op)
          OP_HALT: nextState = S_HALT;
          OP_BNE: begin
            if (!bus.z_flag) begin
              bus.Addr_bus = 1'b1;
              bus.load_PC  = 1'b1;
            end
            nextState = S_FETCH_A;
          end
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_XOR: begin
            bus.Addr_bus = 1'b1;
            bus.load_MAR = 1'b1;
            nextState    = S_EXEC;
          end
          default: nextState = S_FETCH_A;
        endcase
      end
      S_EXEC: begin
        case (bus.op)
          OP_LOAD, OP_ADD, OP_SUB, OP_XOR: begin
            bus.CS       = 1'b1;
            bus.MDR_bus  = 1'b1;
            bus.load_ACC = bus.mem_ready;
            bus.ALU_ACC  = (bus.op == OP_LOAD);
            bus.ALU_add  = (bus.op == OP_ADD);
            bus.ALU_sub  = (bus.op == OP_SUB);
            bus.ALU_xor  = (bus.op == OP_XOR);
            if (bus.mem_ready) nextState = S_FETCH_A;
          end
          OP_STORE: begin
            bus.CS       = 1'b1;
            bus.ACC_bus  = 1'b1;
            bus.load_MDR = 1'b1;
            bus.R_NW     = 1'b0;
            if (bus.mem_ready) nextState = S_FETCH_A;
          end
          default: nextState = S_FETCH_A;
        endcase
      end
      S_HALT:  bus.halted = 1'b1;
      default: nextState = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: every output compared as one packed vector.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cpu_sequencer_if bus();

  cpu_sequencer dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  localparam logic [16:0] M_PC_BUS   = 17'b1 << 16;
  localparam logic [16:0] M_INC_PC   = 17'b1 << 15;
  localparam logic [16:0] M_LOAD_PC  = 17'b1 << 14;
  localparam logic [16:0] M_LOAD_IR  = 17'b1 << 13;
  localparam logic [16:0] M_ADDR_BUS = 17'b1 << 12;
  localparam logic [16:0] M_LOAD_MAR = 17'b1 << 11;
  localparam logic [16:0] M_MDR_BUS  = 17'b1 << 10;
  localparam logic [16:0] M_LOAD_MDR = 17'b1 << 9;
  localparam logic [16:0] M_CS       = 17'b1 << 8;
  localparam logic [16:0] M_R_NW     = 17'b1 << 7;
  localparam logic [16:0] M_ACC_BUS  = 17'b1 << 6;
  localparam logic [16:0] M_LOAD_ACC = 17'b1 << 5;
  localparam logic [16:0] M_ALU_ACC  = 17'b1 << 4;
  localparam logic [16:0] M_ALU_ADD  = 17'b1 << 3;
  localparam logic [16:0] M_ALU_SUB  = 17'b1 << 2;
  localparam logic [16:0] M_ALU_XOR  = 17'b1 << 1;
  localparam logic [16:0] M_HALTED   = 17'b1;

  localparam logic [16:0] E_IDLE    = M_R_NW;
  localparam logic [16:0] E_FETCHA  = M_PC_BUS | M_INC_PC | M_LOAD_MAR | M_R_NW;
  localparam logic [16:0] E_FDWAIT  = M_CS | M_R_NW | M_MDR_BUS;
  localparam logic [16:0] E_FETCHD  = E_FDWAIT | M_LOAD_IR;
  localparam logic [16:0] E_DECMEM  = M_ADDR_BUS | M_LOAD_MAR | M_R_NW;
  localparam logic [16:0] E_BNE     = M_ADDR_BUS | M_LOAD_PC | M_R_NW;
  localparam logic [16:0] E_STORE   = M_ACC_BUS | M_LOAD_MDR | M_CS;
  localparam logic [16:0] E_HALT    = M_HALTED | M_R_NW;
  localparam logic [16:0] E_EXRD    = M_CS | M_R_NW | M_MDR_BUS;

  function automatic logic [16:0] outs();
    return {bus.PC_bus, bus.INC_PC, bus.load_PC, bus.load_IR, bus.Addr_bus,
            bus.load_MAR, bus.MDR_bus, bus.load_MDR, bus.CS, bus.R_NW,
            bus.ACC_bus, bus.load_ACC, bus.ALU_ACC, bus.ALU_add, bus.ALU_sub,
            bus.ALU_xor, bus.halted};
  endfunction

  task automatic applyStimulus(input logic [2:0] opV, input logic readyV, input logic zV);
    bus.op = opV;
    bus.mem_ready = readyV;
    bus.z_flag = zV;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset hold, release, then a full LOAD instruction back to fetch.
  task automatic test_reset();
    applyStimulus(OP_LOAD, 1'b1, 1'b0);
    n_reset = 1'b0;
    tick();
    tick();
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL reset_hold got=%h exp=%h", outs(), E_IDLE); end
    n_reset = 1'b1;
    #1;
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL reset_release got=%h exp=%h", outs(), E_IDLE); end
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL load_fetch_a got=%h exp=%h", outs(), E_FETCHA); end
    tick();
    checks++;
    if (outs() !== E_FETCHD) begin failures++; $display("[TB] FAIL load_fetch_d got=%h exp=%h", outs(), E_FETCHD); end
    tick();
    checks++;
    if (outs() !== E_DECMEM) begin failures++; $display("[TB] FAIL load_decode got=%h exp=%h", outs(), E_DECMEM); end
    tick();
    checks++;
    if (outs() !== (E_EXRD | M_ALU_ACC | M_LOAD_ACC)) begin
      failures++; $display("[TB] FAIL load_exec got=%h exp=%h", outs(), E_EXRD | M_ALU_ACC | M_LOAD_ACC);
    end
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL load_refetch got=%h exp=%h", outs(), E_FETCHA); end
  endtask

  // STORE with two wait cycles in execute: write strobes held three cycles.
  task automatic test_store_wait();
    applyStimulus(OP_STORE, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (outs() !== E_DECMEM) begin failures++; $display("[TB] FAIL store_decode got=%h exp=%h", outs(), E_DECMEM); end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs() !== E_STORE) begin failures++; $display("[TB] FAIL store_wait%0d got=%h exp=%h", i, outs(), E_STORE); end
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== E_STORE) begin failures++; $display("[TB] FAIL store_done got=%h exp=%h", outs(), E_STORE); end
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL store_refetch got=%h exp=%h", outs(), E_FETCHA); end
  endtask

  // Fetch wait states, BNE taken/not taken, and NOP.
  task automatic test_bne();
    applyStimulus(OP_BNE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (outs() !== E_FDWAIT) begin failures++; $display("[TB] FAIL fetch_wait%0d got=%h exp=%h", i, outs(), E_FDWAIT); end
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== E_FETCHD) begin failures++; $display("[TB] FAIL fetch_ready got=%h exp=%h", outs(), E_FETCHD); end
    tick();
    checks++;
    if (outs() !== E_BNE) begin failures++; $display("[TB] FAIL bne_taken got=%h exp=%h", outs(), E_BNE); end
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL bne_taken_ret got=%h exp=%h", outs(), E_FETCHA); end
    bus.z_flag = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL bne_not_taken got=%h exp=%h", outs(), E_IDLE); end
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL bne_nt_ret got=%h exp=%h", outs(), E_FETCHA); end
    applyStimulus(OP_NOP, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL nop_decode got=%h exp=%h", outs(), E_IDLE); end
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL nop_ret got=%h exp=%h", outs(), E_FETCHA); end
  endtask

  // Each ALU opcode selects its own ALU strobe; load_ACC waits for mem_ready.
  task automatic test_alu_ops();
    logic [2:0]  opTab [4] = '{OP_LOAD, OP_ADD, OP_SUB, OP_XOR};
    logic [16:0] aluTab[4] = '{M_ALU_ACC, M_ALU_ADD, M_ALU_SUB, M_ALU_XOR};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(opTab[k], 1'b1, 1'b0);
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      checks++;
      if (outs() !== (E_EXRD | aluTab[k])) begin
        failures++; $display("[TB] FAIL alu_wait op=%0d got=%h exp=%h", opTab[k], outs(), E_EXRD | aluTab[k]);
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (outs() !== (E_EXRD | aluTab[k] | M_LOAD_ACC)) begin
        failures++; $display("[TB] FAIL alu_ready op=%0d got=%h exp=%h", opTab[k], outs(), E_EXRD | aluTab[k] | M_LOAD_ACC);
      end
      tick();
      checks++;
      if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL alu_ret op=%0d got=%h exp=%h", opTab[k], outs(), E_FETCHA); end
    end
  endtask

  // HALT holds indefinitely; only reset leaves it.
  task automatic test_halt();
    applyStimulus(OP_HALT, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL halt_decode got=%h exp=%h", outs(), E_IDLE); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (outs() !== E_HALT) begin failures++; $display("[TB] FAIL halt_hold%0d got=%h exp=%h", i, outs(), E_HALT); end
    end
    n_reset = 1'b0;
    #1;
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL halt_reset got=%h exp=%h", outs(), E_IDLE); end
    tick();
    n_reset = 1'b1;
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL halt_restart got=%h exp=%h", outs(), E_FETCHA); end
  endtask

  // Async reset during ADD execute clears outputs at once and suppresses load_ACC.
  task automatic test_reset_mid_exec();
    applyStimulus(OP_ADD, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checks++;
    if (outs() !== (E_EXRD | M_ALU_ADD | M_LOAD_ACC)) begin
      failures++; $display("[TB] FAIL add_exec got=%h exp=%h", outs(), E_EXRD | M_ALU_ADD | M_LOAD_ACC);
    end
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL midexec_reset got=%h exp=%h", outs(), E_IDLE); end
    tick();
    checks++;
    if (outs() !== E_IDLE) begin failures++; $display("[TB] FAIL midexec_hold got=%h exp=%h", outs(), E_IDLE); end
    n_reset = 1'b1;
    tick();
    checks++;
    if (outs() !== E_FETCHA) begin failures++; $display("[TB] FAIL midexec_restart got=%h exp=%h", outs(), E_FETCHA); end
  endtask

  // Random traffic: bus drivers one-hot-or-zero, never INC_PC with load_PC.
  task automatic test_random();
    logic [3:0] drivers;
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (bus.halted) begin
        n_reset = 1'b0;
        #1;
        n_reset = 1'b1;
      end
      tick();
      drivers = {bus.PC_bus, bus.Addr_bus, bus.MDR_bus, bus.ACC_bus};
      checks++;
      if (!$onehot0(drivers) || (bus.INC_PC && bus.load_PC)) begin
        failures++;
        $display("[TB] FAIL random_rules cycle=%0d drivers=%b inc=%b ldpc=%b exp=onehot0,not_both", c, drivers, bus.INC_PC, bus.load_PC);
      end
    end
  endtask

  task automatic checkOutput();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_store_wait();
    test_bne();
    test_alu_ops();
    test_halt();
    test_reset_mid_exec();
    test_random();
    checkOutput();
    $finish;
  end

endmodule
